// File: rtl/branch_resolve_queue.sv
// In-order queue of in-flight predicted branches. Resolves the oldest entry,
// drives predictor training one cycle later and flushes younger entries on a mispredict.
module branch_resolve_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             alloc_valid_i,
    output logic             alloc_ready_o,
    input  logic [15:0]      alloc_pc_i,
    input  logic             alloc_taken_i,
    input  logic [7:0]       alloc_history_i,
    input  logic             resolve_valid_i,
    input  logic             resolve_taken_i,
    output logic             train_valid_o,
    output logic             train_taken_o,
    output logic             train_mispredicted_o,
    output logic [7:0]       train_history_o,
    output logic [15:0]      train_pc_o,
    output logic             flush_o,
    output logic [PTR_W:0]   count_o,
    output logic             underflow_err_o
);

    localparam int CNT_W = PTR_W + 1;

    logic [15:0]      pc_mem    [DEPTH];
    logic             taken_mem [DEPTH];
    logic [7:0]       hist_mem  [DEPTH];

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             underflow_q, underflow_d;

    logic             train_valid_q, train_valid_d;
    logic             train_taken_q, train_taken_d;
    logic             train_mis_q, train_mis_d;
    logic [7:0]       train_hist_q, train_hist_d;
    logic [15:0]      train_pc_q, train_pc_d;
    logic             flush_q, flush_d;

    logic             empty, full;
    logic             alloc_acc, alloc_wr, resolve_acc, mispredict;
    logic [PTR_W-1:0] head_inc;

    assign empty       = (count_q == '0);
    assign full        = (count_q == CNT_W'(DEPTH));
    assign alloc_acc   = alloc_valid_i && !full;
    assign resolve_acc = resolve_valid_i && !empty;
    assign mispredict  = resolve_acc && (resolve_taken_i != taken_mem[head_q]);
    // A mispredicting resolve discards the same-cycle alloc along with younger entries.
    assign alloc_wr    = alloc_acc && !mispredict;
    assign head_inc    = head_q + PTR_W'(1);

    always_comb begin
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
        underflow_d   = underflow_q | (resolve_valid_i && empty);
        train_valid_d = resolve_acc;
        train_mis_d   = mispredict;
        train_taken_d = train_taken_q;
        train_hist_d  = train_hist_q;
        train_pc_d    = train_pc_q;
        flush_d       = mispredict;

        if (resolve_acc) begin
            train_taken_d = resolve_taken_i;
            train_hist_d  = hist_mem[head_q];
            train_pc_d    = pc_mem[head_q];
        end

        if (mispredict) begin
            head_d  = head_inc;
            tail_d  = head_inc;
            count_d = '0;
        end else begin
            if (resolve_acc) head_d = head_inc;
            if (alloc_wr)    tail_d = tail_q + PTR_W'(1);
            case ({alloc_wr, resolve_acc})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            underflow_q   <= 1'b0;
            train_valid_q <= 1'b0;
            train_taken_q <= 1'b0;
            train_mis_q   <= 1'b0;
            train_hist_q  <= '0;
            train_pc_q    <= '0;
            flush_q       <= 1'b0;
        end else begin
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            underflow_q   <= underflow_d;
            train_valid_q <= train_valid_d;
            train_taken_q <= train_taken_d;
            train_mis_q   <= train_mis_d;
            train_hist_q  <= train_hist_d;
            train_pc_q    <= train_pc_d;
            flush_q       <= flush_d;
        end
    end

    // Entry payload needs no reset: occupancy is tracked by count/pointers only.
    always_ff @(posedge clk_i) begin
        if (alloc_wr) begin
            pc_mem[tail_q]    <= alloc_pc_i;
            taken_mem[tail_q] <= alloc_taken_i;
            hist_mem[tail_q]  <= alloc_history_i;
        end
    end

    assign alloc_ready_o        = !full;
    assign train_valid_o        = train_valid_q;
    assign train_taken_o        = train_taken_q;
    assign train_mispredicted_o = train_mis_q;
    assign train_history_o      = train_hist_q;
    assign train_pc_o           = train_pc_q;
    assign flush_o              = flush_q;
    assign count_o              = count_q;
    assign underflow_err_o      = underflow_q;

endmodule

// File: doc/branch_resolve_queue.md
Name: branch_resolve_queue

Overview:
- In-order FIFO of in-flight predicted branches between fetch and execute.
- Holds each branch's PC, predicted direction and the global history snapshot taken at prediction time.
- When execute resolves the oldest branch, compares the outcome with the prediction and drives the predictor's training interface (train_valid/taken/mispredicted/history/pc).
- On a misprediction, flushes all younger entries and raises a flush pulse to the front end.

Parameters:
- DEPTH, 4, number of entries; power of two, 2..16.
- PTR_W, 2, log2(DEPTH).

Ports:
- CLK  input  1  clock, rising edge.
- RES  input  1  reset, asynchronous, active-low.
- alloc_valid  input  1  fetch presents a predicted branch.
- alloc_ready  output  1  queue can accept; equals !full.
- alloc_pc  input  16  branch PC.
- alloc_taken  input  1  predicted direction (predict_taken).
- alloc_history  input  8  history at prediction (predict_history).
- resolve_valid  input  1  execute resolves the oldest branch this cycle.
- resolve_taken  input  1  actual direction.
- train_valid  output  1  training strobe, one cycle.
- train_taken  output  1  actual outcome.
- train_mispredicted  output  1  prediction differed from outcome.
- train_history  output  8  stored history of the trained branch.
- train_pc  output  16  stored PC of the trained branch.
- flush  output  1  one-cycle pulse on misprediction.
- count  output  PTR_W+1  current occupancy, 0..DEPTH.
- underflow_err  output  1  sticky: resolve seen while queue empty.

Behaviour:
- Reset (RES low, async):
  - head = tail = count = 0.
  - All train_* outputs 0, flush 0, underflow_err 0.
  - Entry contents are don't-care.
- Storage and pointers:
  - Circular buffer; head/tail wrap modulo DEPTH.
  - count is a register, not derived from the pointers, so full and empty are unambiguous.
- Allocate:
  - Accepted when alloc_valid && alloc_ready.
  - Writes {pc, taken, history} at tail; tail+1.
- Resolve:
  - Accepted when resolve_valid && count != 0 (head entry).
  - mispredict = resolve_taken != entry.taken.
- Training output (registered, latency 1):
  - The cycle after an accepted resolve: train_valid=1, train_taken=resolve_taken, train_mispredicted=mispredict, train_history/train_pc = head entry fields.
  - Otherwise train_valid=0 and train_mispredicted=0; train_taken/history/pc hold their last values.
- Flush:
  - flush asserts in the same cycle as train_valid && train_mispredicted.
  - Flush is applied in the resolve cycle: next state is head=tail=head+1, count=0. All younger entries are discarded.
  - An alloc in the same cycle as a mispredicting resolve is dropped even if alloc_ready was 1. alloc_ready itself is not lowered combinationally.
- Simultaneous events:
  - Correct resolve + accepted alloc: count unchanged, both pointers advance.
  - When full, alloc_ready=0 even if a resolve is accepted the same cycle. No bypass of a full queue.
  - Resolve + alloc when count==0: the resolve is invalid (underflow). The alloc is still accepted.
- Underflow:
  - resolve_valid with count==0 sets underflow_err and leaves state unchanged. No train_valid.
  - underflow_err clears only on reset.
- States per entry: EMPTY→VALID on alloc; VALID→EMPTY on resolve or flush. No other states.
- Reset mid-operation: all entries are discarded immediately. Any train_valid or flush pending for the next edge is cancelled; outputs go low asynchronously.

Test Plan:
- Reset, alloc pc=0x0010 taken=1 hist=0x5A, then resolve_taken=1 → next cycle: train_valid=1, mispredicted=0, train_pc=0x0010, train_history=0x5A, flush=0; count=0.
- Fill 4 entries (pc 0x20,0x22,0x24,0x26) → alloc_ready=0 and count=4; a 5th alloc is not accepted; resolve all correctly → train_pc order 0x20,0x22,0x24,0x26 with pointers wrapped.
- 3 entries queued, first predicted 0 and resolved 1 → train_mispredicted=1, flush=1 for one cycle, count=0; a later alloc lands correctly and trains with its own fields.
- Mispredicting resolve while alloc_valid=1 (pc 0x40) → alloc dropped, count=0, and no later training with pc 0x40.
- Empty queue, resolve_valid=1 → underflow_err=1 and sticky, no train_valid; a following alloc/resolve pair works normally.
- Queue at count=2 with alloc and correct resolve in the same cycle, repeated 10 cycles → count stays 2, training order matches allocation order; async RES low mid-run → all outputs 0 immediately.
